// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: constants and state type shared by the I2S receive path
package i2s_rx_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int SLOT_W_DEF = 32;
  localparam logic LRC_LEFT = 1'b0;
  typedef enum logic {HUNT, RUN} state_t;
endpackage

// File: rtl/i2s_rx_sync_edge.sv
// i2s_rx_sync_edge: 2-FF synchronizer plus rising-edge detect for one async input
//   clk_i, rst_i : system clock, sync active-high reset
//   d            : asynchronous input
//   q            : synchronized level
//   rise         : one-cycle pulse on a synchronized 0->1 transition
module i2s_rx_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [2:0] r;
  always_ff @(posedge clk_i) r <= rst_i ? 3'b0 : {r[1:0], d};
  assign q = r[1];
  assign rise = r[1] & ~r[2];
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: slave I2S receiver delivering SAMPLE_W-bit left/right pairs on valid/ready
//   clk_i, rst_i             : system clock (>= 4x bclk), sync active-high reset
//   bclk_i, lrc_i, sda_i     : asynchronous I2S bit clock, word select (0 = left), data
//   left_o, right_o, valid_o : held sample pair and its valid flag
//   ready_i                  : consumer accepts the held pair
//   overflow_o               : pulse when a completed pair is dropped
//   frame_err_o              : pulse on a short slot or lost word select
module i2s_rx import i2s_rx_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bclk_i,
  input  logic                lrc_i,
  input  logic                sda_i,
  output logic [SAMPLE_W-1:0] left_o,
  output logic [SAMPLE_W-1:0] right_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overflow_o,
  output logic                frame_err_o
);
  localparam int CW = $clog2(SLOT_W + 2);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_W - 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_W);
  localparam logic [CW-1:0] OVER = CW'(SLOT_W);
  localparam logic [CW-1:0] SAT = CW'(SLOT_W + 1);
  state_t st, st_n;
  logic bit_edge, bclk, lrc, sda, lrc_rise, sda_rise, unused;
  logic lrc_prev, chan, have_left, boundary, word_done, frame_err, pair;
  logic [CW-1:0] bit_cnt;
  logic [SAMPLE_W-1:0] shreg, left_hold, word;
  i2s_rx_sync_edge u_bclk (.clk_i(clk_i), .rst_i(rst_i), .d(bclk_i), .q(bclk), .rise(bit_edge));
  i2s_rx_sync_edge u_lrc (.clk_i(clk_i), .rst_i(rst_i), .d(lrc_i), .q(lrc), .rise(lrc_rise));
  i2s_rx_sync_edge u_sda (.clk_i(clk_i), .rst_i(rst_i), .d(sda_i), .q(sda), .rise(sda_rise));
  assign unused = ^{bclk, lrc_rise, sda_rise};
  always_ff @(posedge clk_i) st <= rst_i ? HUNT : st_n;
  // word includes the bit sampled on this edge so a pair can load one cycle after its last bit
  always_comb begin
    boundary = lrc != lrc_prev;
    word = {shreg[SAMPLE_W-2:0], sda};
    word_done = bit_edge && st == RUN && !boundary && bit_cnt == LAST;
    frame_err = bit_edge && st == RUN && (boundary ? bit_cnt < FULL : bit_cnt == OVER);
    pair = word_done && chan && have_left;
    st_n = frame_err ? HUNT : (bit_edge && boundary && lrc == LRC_LEFT) ? RUN : st;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrc_prev <= 1'b0;
      chan <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      left_hold <= '0;
      have_left <= 1'b0;
      left_o <= '0;
      right_o <= '0;
      valid_o <= 1'b0;
      overflow_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      frame_err_o <= frame_err;
      if (bit_edge) begin
        lrc_prev <= lrc;
        if (boundary) begin
          bit_cnt <= '0;
          chan <= lrc;
        end else begin
          if (bit_cnt < FULL) shreg <= word;
          if (bit_cnt != SAT) bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_err) have_left <= 1'b0;
      else if (word_done && !chan) begin
        left_hold <= word;
        have_left <= 1'b1;
      end else if (word_done) have_left <= 1'b0;
      if (pair && (!valid_o || ready_i)) begin
        left_o <= left_hold;
        right_o <= word;
        valid_o <= 1'b1;
      end else begin
        overflow_o <= pair;
        if (ready_i) valid_o <= 1'b0;
      end
    end
  end
endmodule
